fetch_seq: RTL and testbench

//  Fetch-stage sequencer for the 5-stage MIPS pipeline. Owns the PC and drives a

---
 rtl/fetch_seq.sv | 139 +++++++++++++
 tb/tb_fetch_seq.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_seq.sv
// Fetch-stage sequencer: owns the PC, drives a req/ack instruction-memory port
// and feeds {pc, pc+4, ir} to decode through an output slot plus one skid entry.
module fetch_seq #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  output logic        f_valid,
  output logic [31:0] f_pc,
  output logic [31:0] f_pc4,
  output logic [31:0] f_ir
);

  typedef enum logic [1:0] {FETCH, SKID, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        f_valid_q, f_valid_d;
  logic [31:0] f_pc_q, f_pc_d;
  logic [31:0] f_ir_q, f_ir_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_ir_q, skid_ir_d;

  logic        consume;
  logic        out_free;
  logic        redir;
  logic [31:0] redir_pc;

  assign consume  = f_valid_q & ~stall;
  assign out_free = ~f_valid_q | consume;
  assign redir    = redirect_valid & ~stall;
  assign redir_pc = {redirect_pc[31:2], 2'b00};

  // im_req is gated by reset directly so the port is quiet for the whole reset pulse.
  assign im_req  = ~reset & (state_q != SKID);
  assign im_addr = req_pc_q;
  assign f_valid = f_valid_q;
  assign f_pc    = f_pc_q;
  assign f_pc4   = f_pc_q + 32'd4;
  assign f_ir    = f_ir_q;

  always_comb begin
    state_d      = state_q;
    req_pc_d     = req_pc_q;
    pend_pc_d    = pend_pc_q;
    f_valid_d    = f_valid_q & ~consume;
    f_pc_d       = f_pc_q;
    f_ir_d       = f_ir_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_ir_d    = skid_ir_q;

    unique case (state_q)
      FETCH: begin
        if (redir) begin
          if (im_ack) begin
            req_pc_d = redir_pc;
          end else begin
            // The outstanding request must still complete; remember where to go next.
            pend_pc_d = redir_pc;
            state_d   = DRAIN;
          end
        end else if (im_ack) begin
          req_pc_d = req_pc_q + 32'd4;
          if (out_free) begin
            f_valid_d = 1'b1;
            f_pc_d    = req_pc_q;
            f_ir_d    = im_rdata;
          end else begin
            skid_valid_d = 1'b1;
            skid_pc_d    = req_pc_q;
            skid_ir_d    = im_rdata;
            state_d      = SKID;
          end
        end
      end
      SKID: begin
        if (redir) begin
          req_pc_d = redir_pc;
          state_d  = FETCH;
        end else if (consume) begin
          f_valid_d    = 1'b1;
          f_pc_d       = skid_pc_q;
          f_ir_d       = skid_ir_q;
          skid_valid_d = 1'b0;
          state_d      = FETCH;
        end
      end
      DRAIN: begin
        if (im_ack) begin
          req_pc_d = redir ? redir_pc : pend_pc_q;
          state_d  = FETCH;
        end else if (redir) begin
          pend_pc_d = redir_pc;
        end
      end
      default: state_d = FETCH;
    endcase

    if (redir) begin
      f_valid_d    = 1'b0;
      skid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= FETCH;
      req_pc_q     <= RESET_PC;
      pend_pc_q    <= RESET_PC;
      f_valid_q    <= 1'b0;
      f_pc_q       <= 32'd0;
      f_ir_q       <= 32'd0;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= 32'd0;
      skid_ir_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      req_pc_q     <= req_pc_d;
      pend_pc_q    <= pend_pc_d;
      f_valid_q    <= f_valid_d;
      f_pc_q       <= f_pc_d;
      f_ir_q       <= f_ir_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_ir_q    <= skid_ir_d;
    end
  end

endmodule

// File: tb/tb_fetch_seq.sv
// Bench for fetch_seq: a variable-latency memory responder, a program-order
// scoreboard on everything decode consumes, and directed scenario tasks.
`timescale 1ns/100ps
module tb_fetch_seq;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack;
  logic [31:0] im_rdata;
  logic        f_valid;
  logic [31:0] f_pc;
  logic [31:0] f_pc4;
  logic [31:0] f_ir;

  int          n_assert = 0;
  int          n_fail = 0;
  int          n_consumed = 0;
  int unsigned lat = 0;
  int unsigned cur_lat = 0;
  int unsigned wait_cnt = 0;
  bit          rand_mode = 1'b0;
  bit          pending = 1'b0;
  logic [31:0] held_addr = 32'd0;
  logic [31:0] exp_next = RESET_PC;

  fetch_seq #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .im_req(im_req), .im_addr(im_addr), .im_ack(im_ack), .im_rdata(im_rdata),
    .f_valid(f_valid), .f_pc(f_pc), .f_pc4(f_pc4), .f_ir(f_ir)
  );

  always #10 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // Memory: decides im_ack for the coming edge; checks address stability while pending.
  always @(negedge clk) begin
    #1;
    if (reset || !im_req) begin
      im_ack = 1'b0; im_rdata = $urandom; wait_cnt = 0; pending = 1'b0;
    end else begin
      if (pending) begin
        n_assert++;
        if (im_addr !== held_addr) begin
          n_fail++; $display("FAIL addr_stable got=%h exp=%h", im_addr, held_addr);
        end
      end
      if (wait_cnt == 0) cur_lat = rand_mode ? $urandom_range(0, 3) : lat;
      if (wait_cnt >= cur_lat) begin
        im_ack = 1'b1; im_rdata = mem_word(im_addr); wait_cnt = 0;
      end else begin
        im_ack = 1'b0; im_rdata = $urandom; wait_cnt++;
      end
      pending = !im_ack;
      held_addr = im_addr;
    end
  end

  // Program-order scoreboard: each consumed instruction follows its predecessor
  // by 4, or starts at the last accepted redirect target.
  always @(negedge clk) begin
    #3;
    if (reset) begin
      exp_next = RESET_PC;
    end else begin
      if (f_valid && !stall) begin
        n_assert++;
        n_consumed++;
        if (f_pc !== exp_next || f_ir !== mem_word(f_pc) || f_pc4 !== f_pc + 32'd4) begin
          n_fail++;
          $display("FAIL consume pc=%h ir=%h pc4=%h exp_pc=%h exp_ir=%h", f_pc, f_ir, f_pc4,
                   exp_next, mem_word(exp_next));
        end
        exp_next = f_pc + 32'd4;
      end
      if (redirect_valid && !stall) exp_next = {redirect_pc[31:2], 2'b00};
    end
  end

  task automatic do_reset(input int unsigned l);
    @(negedge clk);
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; lat = l;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk); #2;
    n_assert++;
    if (im_req !== 1'b0 || f_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctl req=%b valid=%b exp 0 0", im_req, f_valid);
    end
    n_assert++;
    if (f_pc !== 32'd0 || f_ir !== 32'd0 || f_pc4 !== 32'd4) begin
      n_fail++; $display("FAIL reset_slot pc=%h ir=%h pc4=%h exp 0 0 4", f_pc, f_ir, f_pc4);
    end
    $display("test_reset done");
  endtask

  // Zero-wait memory streams one instruction per cycle, then a stall forces the skid.
  task automatic test_stream_and_skid();
    do_reset(0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 3) stall = 1'b1;
      #2;
      n_assert++;
      if (im_req !== 1'b1 || im_addr !== RESET_PC + 32'(4 * k)) begin
        n_fail++; $display("FAIL stream_addr k=%0d req=%b got=%h exp=%h", k, im_req, im_addr,
                           RESET_PC + 32'(4 * k));
      end
      n_assert++;
      if (k == 0 ? (f_valid !== 1'b0)
                 : (f_valid !== 1'b1 || f_pc !== RESET_PC + 32'(4 * (k - 1)) ||
                    f_pc4 !== RESET_PC + 32'(4 * k))) begin
        n_fail++; $display("FAIL stream_slot k=%0d valid=%b pc=%h pc4=%h", k, f_valid, f_pc, f_pc4);
      end
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 2) stall = 1'b0;
      #2;
      n_assert++;
      if (im_req !== 1'b0 || f_valid !== 1'b1 || f_pc !== 32'h3008 || f_ir !== mem_word(32'h3008)) begin
        n_fail++; $display("FAIL skid_hold k=%0d req=%b valid=%b pc=%h ir=%h exp 0 1 3008", k, im_req,
                           f_valid, f_pc, f_ir);
      end
    end
    @(negedge clk); #2;
    n_assert++;
    if (f_valid !== 1'b1 || f_pc !== 32'h300C || im_req !== 1'b1 || im_addr !== 32'h3010) begin
      n_fail++; $display("FAIL skid_release valid=%b pc=%h req=%b addr=%h exp 1 300c 1 3010",
                         f_valid, f_pc, im_req, im_addr);
    end
    $display("test_stream_and_skid done");
  endtask

  // Redirect while the 3008 request is still waiting: the request drains, data is dropped.
  task automatic test_redirect_drain();
    int n;
    do_reset(2);
    #2;
    n = 0;
    while (im_addr !== 32'h3008 && n < 30) begin
      @(negedge clk); #2; n++;
    end
    n_assert++;
    if (n >= 30) begin
      n_fail++; $display("FAIL drain_reach addr=%h exp=3008", im_addr);
    end
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_3102;
    #2;
    @(negedge clk);
    redirect_valid = 1'b0;
    #2;
    n_assert++;
    if (im_req !== 1'b1 || im_addr !== 32'h3008 || f_valid !== 1'b0) begin
      n_fail++; $display("FAIL drain_hold req=%b addr=%h valid=%b exp 1 3008 0", im_req, im_addr, f_valid);
    end
    @(negedge clk); #2;
    n_assert++;
    if (im_addr !== 32'h3100 || f_valid !== 1'b0) begin
      n_fail++; $display("FAIL drain_next addr=%h valid=%b exp 3100 0", im_addr, f_valid);
    end
    n = 0;
    while (f_valid !== 1'b1 && n < 20) begin
      @(negedge clk); #2; n++;
    end
    n_assert++;
    if (f_valid !== 1'b1 || f_pc !== 32'h3100) begin
      n_fail++; $display("FAIL drain_target valid=%b pc=%h exp 1 3100", f_valid, f_pc);
    end
    $display("test_redirect_drain done");
  endtask

  task automatic test_redirect_on_ack();
    do_reset(0);
    #2;
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_3200;
    #2;
    n_assert++;
    if (im_addr !== 32'h3004 || f_valid !== 1'b1 || f_pc !== 32'h3000) begin
      n_fail++; $display("FAIL ack_redir_pre addr=%h valid=%b pc=%h exp 3004 1 3000", im_addr, f_valid, f_pc);
    end
    @(negedge clk);
    redirect_valid = 1'b0;
    #2;
    n_assert++;
    if (im_addr !== 32'h3200 || f_valid !== 1'b0) begin
      n_fail++; $display("FAIL ack_redir_flush addr=%h valid=%b exp 3200 0", im_addr, f_valid);
    end
    @(negedge clk); #2;
    n_assert++;
    if (f_valid !== 1'b1 || f_pc !== 32'h3200 || im_addr !== 32'h3204) begin
      n_fail++; $display("FAIL ack_redir_target valid=%b pc=%h addr=%h exp 1 3200 3204", f_valid, f_pc, im_addr);
    end
    $display("test_redirect_on_ack done");
  endtask

  task automatic test_reset_in_drain();
    do_reset(0);
    #2;
    @(negedge clk);
    lat = 3;
    #2;
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_3300;
    #2;
    @(negedge clk);
    redirect_valid = 1'b0;
    #2;
    n_assert++;
    if (im_req !== 1'b1 || im_addr !== 32'h3004 || f_pc !== 32'h3000) begin
      n_fail++; $display("FAIL drain_pre req=%b addr=%h pc=%h exp 1 3004 3000", im_req, im_addr, f_pc);
    end
    #3;
    reset = 1'b1;
    #1;
    n_assert++;
    if (im_req !== 1'b0 || f_valid !== 1'b0 || f_pc !== 32'd0 || f_ir !== 32'd0 || f_pc4 !== 32'd4) begin
      n_fail++; $display("FAIL async_reset req=%b valid=%b pc=%h ir=%h pc4=%h", im_req, f_valid, f_pc, f_ir, f_pc4);
    end
    lat = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #2;
    n_assert++;
    if (im_req !== 1'b1 || im_addr !== RESET_PC) begin
      n_fail++; $display("FAIL reset_restart req=%b addr=%h exp 1 3000", im_req, im_addr);
    end
    $display("test_reset_in_drain done");
  endtask

  task automatic test_redirect_under_stall();
    do_reset(0);
    #2;
    @(negedge clk);
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_3400;
    #2;
    @(negedge clk); #2;
    n_assert++;
    if (im_req !== 1'b0 || f_valid !== 1'b1 || f_pc !== 32'h3000) begin
      n_fail++; $display("FAIL stall_redir_hold req=%b valid=%b pc=%h exp 0 1 3000", im_req, f_valid, f_pc);
    end
    @(negedge clk);
    stall = 1'b0; redirect_valid = 1'b0;
    #2;
    @(negedge clk); #2;
    n_assert++;
    if (f_valid !== 1'b1 || f_pc !== 32'h3004 || im_addr !== 32'h3008) begin
      n_fail++; $display("FAIL stall_redir_seq valid=%b pc=%h addr=%h exp 1 3004 3008", f_valid, f_pc, im_addr);
    end
    $display("test_redirect_under_stall done");
  endtask

  task automatic test_random();
    int start;
    do_reset(0);
    rand_mode = 1'b1;
    start = n_consumed;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      stall = ($urandom_range(0, 9) < 3);
      redirect_valid = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else redirect_pc = 32'h3000 + 32'($urandom_range(0, 255) * 4) + 32'($urandom_range(0, 3));
    end
    @(negedge clk);
    stall = 1'b0; redirect_valid = 1'b0;
    repeat (10) @(negedge clk);
    rand_mode = 1'b0;
    n_assert++;
    if (n_consumed - start < 100) begin
      n_fail++; $display("FAIL random_progress consumed=%0d exp>=100", n_consumed - start);
    end
    $display("test_random done: %0d instructions consumed", n_consumed - start);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    test_reset();
    test_stream_and_skid();
    test_redirect_drain();
    test_redirect_on_ack();
    test_reset_in_drain();
    test_redirect_under_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
